// File: rtl/scan_memory_bank.sv
// Word-addressed register-file memory with registered read, a sequential clear
// engine and a full-array scan chain that takes priority over every other operation.
module scan_memory_bank #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_SIZE   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  addr_err,
    input  logic                  clr_start,
    output logic                  busy,
    output logic                  clr_done,
    input  logic                  scan_enable,
    input  logic                  scan_in,
    output logic                  scan_out
);

    typedef enum logic {IDLE, CLEAR} state_t;

    // One extra bit so MEM_SIZE == 2**ADDR_WIDTH is representable as the limit.
    localparam logic [ADDR_WIDTH:0]   MEM_LIM  = (ADDR_WIDTH+1)'(MEM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MEM_SIZE - 1);

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
    logic [ADDR_WIDTH-1:0] clr_cnt;

    logic                  wr_ok;
    logic                  rd_ok;
    logic                  clr_active;
    logic                  do_wr;
    logic                  wr_err;
    logic                  do_rd;
    logic                  rd_err;
    logic [ADDR_WIDTH-1:0] rd_idx;

    assign wr_ok      = {1'b0, wr_addr} < MEM_LIM;
    assign rd_ok      = {1'b0, rd_addr} < MEM_LIM;
    assign clr_active = (state == CLEAR) && !scan_enable;
    assign do_wr      = wr_en && !scan_enable && (state == IDLE) && wr_ok;
    assign wr_err     = wr_en && !scan_enable && (state == IDLE) && !wr_ok;
    assign do_rd      = rd_en && !scan_enable;
    assign rd_err     = do_rd && !rd_ok;
    // Out-of-range addresses never reach the array decode.
    assign rd_idx     = rd_ok ? rd_addr : '0;
    assign scan_out   = mem[MEM_SIZE-1][DATA_WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_SIZE; i++) begin
                mem[i] <= '0;
            end
        end else if (scan_enable) begin
            mem[0] <= {mem[0][DATA_WIDTH-2:0], scan_in};
            for (int i = 1; i < MEM_SIZE; i++) begin
                mem[i] <= {mem[i][DATA_WIDTH-2:0], mem[i-1][DATA_WIDTH-1]};
            end
        end else if (clr_active) begin
            mem[clr_cnt] <= '0;
        end else if (do_wr) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            clr_cnt  <= '0;
            busy     <= 1'b0;
            clr_done <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            addr_err <= 1'b0;
        end else begin
            rd_valid <= do_rd;
            addr_err <= wr_err || rd_err;
            clr_done <= 1'b0;
            if (do_rd) begin
                rd_data <= rd_ok ? mem[rd_idx] : '0;
            end
            case (state)
                IDLE: begin
                    if (clr_start && !scan_enable) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (!scan_enable) begin
                        if (clr_cnt == LAST_IDX) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            clr_done <= 1'b1;
                        end else begin
                            clr_cnt <= clr_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_memory_bank.sv
// Bench for scan_memory_bank: a 32-word and a 20-word instance share stimulus and
// are both compared every cycle against a bit-vector model of the array.
module tb_scan_memory_bank;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr_en = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       rd_en = 1'b0;
    logic [4:0] rd_addr = '0;
    logic       clr_start = 1'b0;
    logic       scan_enable = 1'b0;
    logic       scan_in = 1'b0;

    logic [7:0] rd_data [2];
    logic       rd_valid [2];
    logic       addr_err [2];
    logic       busy [2];
    logic       clr_done [2];
    logic       scan_out [2];

    always #5 clk = ~clk;

    scan_memory_bank u0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]),
        .addr_err(addr_err[0]), .clr_start(clr_start), .busy(busy[0]), .clr_done(clr_done[0]),
        .scan_enable(scan_enable), .scan_in(scan_in), .scan_out(scan_out[0])
    );

    scan_memory_bank #(.MEM_SIZE(20)) u1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]),
        .addr_err(addr_err[1]), .clr_start(clr_start), .busy(busy[1]), .clr_done(clr_done[1]),
        .scan_enable(scan_enable), .scan_in(scan_in), .scan_out(scan_out[1])
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    endtask

    // Model: the whole array as one bit vector, word i at bits [i*8 +: 8].
    int           sz [2] = '{32, 20};
    logic [255:0] mv [2];
    logic [7:0]   e_rd [2];
    bit           e_rv [2];
    bit           e_ae [2];
    bit           e_busy [2];
    bit           e_cd [2];
    int           cnt [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mv[k] = '0; e_rd[k] = '0; e_rv[k] = 0; e_ae[k] = 0;
            e_busy[k] = 0; e_cd[k] = 0; cnt[k] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            logic [7:0] rdv;
            bit rv, ae, cd;
            rv  = rd_en && !scan_enable;
            rdv = e_rd[k];
            if (rv) rdv = (int'(rd_addr) < sz[k]) ? mv[k][rd_addr*8 +: 8] : 8'h00;
            ae = (rv && int'(rd_addr) >= sz[k]) ||
                 (wr_en && !scan_enable && !e_busy[k] && int'(wr_addr) >= sz[k]);
            cd = 0;
            if (scan_enable) begin
                mv[k] = {mv[k][254:0], scan_in};
            end else if (e_busy[k]) begin
                mv[k][cnt[k]*8 +: 8] = 8'h00;
                if (cnt[k] == sz[k] - 1) begin
                    e_busy[k] = 0;
                    cd = 1;
                end else begin
                    cnt[k]++;
                end
            end else begin
                if (wr_en && int'(wr_addr) < sz[k]) mv[k][wr_addr*8 +: 8] = wr_data;
                if (clr_start) begin
                    e_busy[k] = 1;
                    cnt[k] = 0;
                end
            end
            e_rd[k] = rdv; e_rv[k] = rv; e_ae[k] = ae; e_cd[k] = cd;
        end
    endtask

    always @(negedge rst_n) model_reset();
    always @(posedge clk) if (rst_n) model_step();

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rd_data%0d", k),  rd_data[k],  e_rd[k]);
            chk($sformatf("rd_valid%0d", k), rd_valid[k], e_rv[k]);
            chk($sformatf("addr_err%0d", k), addr_err[k], e_ae[k]);
            chk($sformatf("busy%0d", k),     busy[k],     e_busy[k]);
            chk($sformatf("clr_done%0d", k), clr_done[k], e_cd[k]);
            chk($sformatf("scan_out%0d", k), scan_out[k], mv[k][sz[k]*8-1]);
        end
    end

    task automatic drive(input bit se, input bit si, input bit we, input logic [4:0] wa,
                         input logic [7:0] wd, input bit re, input logic [4:0] ra, input bit cs);
        @(negedge clk);
        scan_enable = se; scan_in = si; wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_addr = ra; clr_start = cs;
    endtask

    task automatic idle();
        drive(0, 0, 0, 5'd0, 8'h00, 0, 5'd0, 0);
    endtask

    function automatic bit pat(input int k);
        return (k % 3) == 0;
    endfunction

    function automatic logic [7:0] pat_word(input int i);
        logic [7:0] w;
        for (int j = 0; j < 8; j++) w[j] = pat(255 - (i*8 + j));
        return w;
    endfunction

    task automatic readback_zero(input string nm);
        for (int a = 0; a < 32; a++) begin
            drive(0, 0, 0, 5'(a), 8'h00, 1, 5'(a), 0);
            idle();
            chk(nm, rd_data[0], 8'h00);
        end
    endtask

    initial begin
        int busy_cnt;
        bit done_flag;
        int c;

        #1 rst_n = 1'b0;
        model_reset();
        #2;
        chk("reset_busy", busy[0], 1'b0);
        chk("reset_rd_valid", rd_valid[0], 1'b0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Write then read.
        drive(0, 0, 1, 5'd3, 8'hA5, 0, 5'd0, 0);
        drive(0, 0, 0, 5'd0, 8'h00, 1, 5'd3, 0);
        idle();
        chk("rd_a5_valid", rd_valid[0], 1'b1);
        chk("rd_a5_data", rd_data[0], 8'hA5);
        idle();
        chk("rd_valid_pulse", rd_valid[0], 1'b0);
        chk("rd_data_hold", rd_data[0], 8'hA5);

        // Read-first on same-address write.
        drive(0, 0, 1, 5'd7, 8'h11, 0, 5'd0, 0);
        drive(0, 0, 1, 5'd7, 8'h3C, 1, 5'd7, 0);
        drive(0, 0, 0, 5'd0, 8'h00, 1, 5'd7, 0);
        chk("rd_first_old", rd_data[0], 8'h11);
        idle();
        chk("rd_first_new", rd_data[0], 8'h3C);

        // Out-of-range on the 20-word instance (in range on the 32-word one).
        drive(0, 0, 1, 5'd25, 8'h5A, 0, 5'd0, 0);
        idle();
        chk("oor_wr_err1", addr_err[1], 1'b1);
        chk("oor_wr_err0", addr_err[0], 1'b0);
        drive(0, 0, 0, 5'd0, 8'h00, 1, 5'd25, 0);
        idle();
        chk("oor_rd_err1", addr_err[1], 1'b1);
        chk("oor_rd_valid1", rd_valid[1], 1'b1);
        chk("oor_rd_data1", rd_data[1], 8'h00);
        chk("inrange_rd_data0", rd_data[0], 8'h5A);
        for (int a = 0; a < 32; a++) drive(0, 0, 0, 5'd0, 8'h00, 1, 5'(a), 0);
        idle();

        // Clear with a 5-cycle scan suspension and writes issued while busy.
        for (int a = 0; a < 32; a++) drive(0, 0, 1, 5'(a), 8'hFF, 0, 5'd0, 0);
        drive(0, 0, 0, 5'd0, 8'h00, 0, 5'd0, 1);
        busy_cnt = 0; done_flag = 0; c = 0;
        while (c < 100) begin
            @(negedge clk);
            if (!busy[0]) begin
                done_flag = clr_done[0];
                break;
            end
            busy_cnt++;
            scan_enable = (c >= 10 && c < 15); scan_in = 0; wr_en = 1; wr_addr = 5'(c);
            wr_data = 8'h77; rd_en = 0; clr_start = 0;
            c++;
        end
        scan_enable = 0; wr_en = 0;
        chk("clear_busy_cycles", busy_cnt, 37);
        chk("clear_done_pulse", done_flag, 1'b1);
        idle();
        chk("clear_done_once", clr_done[0], 1'b0);
        readback_zero("clear_word_zero");

        // Scan a 256-bit pattern in, read it back, then shift it out.
        for (int t = 0; t < 256; t++) drive(1, pat(t), 0, 5'd0, 8'h00, 0, 5'd0, 0);
        idle();
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 0, 5'd0, 8'h00, 1, 5'(i), 0);
            idle();
            chk($sformatf("scan_word%0d", i), rd_data[0], pat_word(i));
        end
        chk("scan_word0_lit", pat_word(0), 8'h49);
        scan_enable = 1; scan_in = 0;
        for (int t = 0; t < 256; t++) begin
            chk($sformatf("scan_out_bit%0d", t), scan_out[0], pat(t));
            @(negedge clk);
        end
        scan_enable = 0;
        idle();

        // Reset mid-clear at counter 10.
        for (int a = 0; a < 32; a++) drive(0, 0, 1, 5'(a), 8'(a + 1), 0, 5'd0, 0);
        drive(0, 0, 0, 5'd0, 8'h00, 1, 5'd4, 1);
        repeat (10) idle();
        chk("midclr_busy_before", busy[0], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("midclr_rst_busy", busy[0], 1'b0);
        chk("midclr_rst_rd_data", rd_data[0], 8'h00);
        chk("midclr_rst_rd_valid", rd_valid[0], 1'b0);
        chk("midclr_rst_addr_err", addr_err[0], 1'b0);
        chk("midclr_rst_clr_done", clr_done[0], 1'b0);
        chk("midclr_rst_scan_out", scan_out[0], 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            idle();
            chk("midclr_no_done", clr_done[0], 1'b0);
        end
        readback_zero("midclr_word_zero");

        // Randomized traffic, with one asynchronous reset in the middle.
        for (int i = 0; i < 1500; i++) begin
            if (i == 750) begin
                @(posedge clk);
                #3 rst_n = 1'b0;
                @(posedge clk);
                #3 rst_n = 1'b1;
            end
            drive(($urandom_range(15) == 0), 1'($urandom), 1'($urandom), 5'($urandom_range(31)),
                  8'($urandom), 1'($urandom), 5'($urandom_range(31)), ($urandom_range(31) == 0));
        end
        c = 0;
        idle();
        while ((busy[0] || busy[1]) && c < 200) begin
            idle();
            c++;
        end
        chk("final_idle", busy[0] || busy[1], 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
